f_pc_unit: RTL and testbench

//   Fetch-stage PC register and next-PC selection for the 5-stage MIPS pipeline.

---
 rtl/f_pc_unit_pkg.sv | 17 +
 rtl/f_pc_unit_npc_calc.sv | 35 +++
 rtl/f_pc_unit.sv | 70 +++++++
 tb/tb_f_pc_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/f_pc_unit_pkg.sv
// Shared encodings for the fetch PC unit: jump-type codes, the fetch exception code
// and the default reset / handler-entry addresses.
package f_pc_unit_pkg;

    typedef enum logic [1:0] {
        J_NONE = 2'd0,
        J_BR   = 2'd1,
        J_J    = 2'd2,
        J_JR   = 2'd3
    } jtype_e;

    localparam logic [4:0]  EXC_ADEL      = 5'd4;
    localparam logic [4:0]  EXC_NONE      = 5'd0;
    localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;

endpackage

// File: rtl/f_pc_unit_npc_calc.sv
// Combinational next-PC for the free-running case: taken branch, J/JAL, JR/JALR,
// otherwise sequential fetch from the current F-stage PC.
module f_npc_calc
    import f_pc_unit_pkg::*;
(
    input  logic [31:0] F_pc,
    input  logic [31:0] D_pc,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_index26,
    input  logic [31:0] D_rs,
    input  logic        D_brjump,
    input  logic [1:0]  D_jtype,
    output logic [31:0] npc
);

    logic        [31:0] d_pc_plus4;
    logic        [31:0] f_pc_plus4;
    logic signed [31:0] br_off;

    assign d_pc_plus4 = D_pc + 32'd4;
    assign f_pc_plus4 = F_pc + 32'd4;
    assign br_off     = {{14{D_imm16[15]}}, D_imm16, 2'b00};

    always_comb begin
        npc = f_pc_plus4;
        case (jtype_e'(D_jtype))
            J_BR:    if (D_brjump) npc = d_pc_plus4 + $unsigned(br_off);
            // Region bits come from the delay-slot address, so a carry into [31:28] counts.
            J_J:     npc = {d_pc_plus4[31:28], D_index26, 2'b00};
            J_JR:    npc = D_rs;
            default: npc = f_pc_plus4;
        endcase
    end

endmodule

// File: rtl/f_pc_unit.sv
// Fetch-stage PC register with reset/exception/eret/stall priority and delay-slot flag.
// Optional macro FETCH_ADEL_EN builds the fetch address-error (AdEL) check on F_pc.
module f_pc_unit
    import f_pc_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_LO     = 32'h0000_3000,
    parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] EPC,
    input  logic [31:0] D_pc,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_index26,
    input  logic [31:0] D_rs,
    input  logic        D_brjump,
    input  logic [1:0]  D_jtype,
    output logic [31:0] F_pc,
    output logic        F_bd,
    output logic [4:0]  F_exc_code
);

    logic [31:0] npc;

    f_npc_calc u_npc (
        .F_pc      (F_pc),
        .D_pc      (D_pc),
        .D_imm16   (D_imm16),
        .D_index26 (D_index26),
        .D_rs      (D_rs),
        .D_brjump  (D_brjump),
        .D_jtype   (D_jtype),
        .npc       (npc)
    );

    // F stage register: exception entry and eret override a stall so no cycle is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            F_pc <= PC_RESET;
            F_bd <= 1'b0;
        end else if (req) begin
            F_pc <= EXC_ENTRY;
            F_bd <= 1'b0;
        end else if (eret) begin
            F_pc <= EPC;
            F_bd <= 1'b0;
        end else if (!stall) begin
            F_pc <= npc;
            F_bd <= (jtype_e'(D_jtype) != J_NONE);
        end
    end

`ifdef FETCH_ADEL_EN
    function automatic logic [4:0] fetch_adel(input logic [31:0] pc);
        if (pc[1:0] != 2'b00 || pc < IM_LO || pc > IM_HI)
            return EXC_ADEL;
        return EXC_NONE;
    endfunction

    assign F_exc_code = fetch_adel(F_pc);
`else
    assign F_exc_code = EXC_NONE;
`endif

endmodule

// File: tb/tb_f_pc_unit.sv
// Table-driven bench for f_pc_unit with an expected-value queue popped after each edge.
module tb_f_pc_unit;
    import f_pc_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, req, eret, D_brjump;
    logic [31:0] EPC, D_pc, D_rs;
    logic [15:0] D_imm16;
    logic [25:0] D_index26;
    logic [1:0]  D_jtype;
    logic [31:0] F_pc;
    logic        F_bd;
    logic [4:0]  F_exc_code;

    f_pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .req        (req),
        .eret       (eret),
        .EPC        (EPC),
        .D_pc       (D_pc),
        .D_imm16    (D_imm16),
        .D_index26  (D_index26),
        .D_rs       (D_rs),
        .D_brjump   (D_brjump),
        .D_jtype    (D_jtype),
        .F_pc       (F_pc),
        .F_bd       (F_bd),
        .F_exc_code (F_exc_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stl, rq, er;
        logic [31:0] epc, dpc;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rs;
        logic        brj;
        logic [1:0]  jt;
        logic [31:0] exp_pc;
        logic        exp_bd;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [4:0] model_exc(input logic [31:0] pc);
`ifdef FETCH_ADEL_EN
        if (pc[1:0] != 2'b00 || pc < 32'h3000 || pc > 32'h6FFC) return 5'd4;
        return 5'd0;
`else
        return (pc == 32'hDEAD_BEEF) ? 5'd1 : 5'd0;
`endif
    endfunction

    task automatic add(input logic rst, stl, rq, er, input logic [31:0] epc, dpc,
                       input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs,
                       input logic brj, input logic [1:0] jt,
                       input logic [31:0] exp_pc, input logic exp_bd);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rq = rq; v.er = er; v.epc = epc; v.dpc = dpc;
        v.imm = imm; v.idx = idx; v.rs = rs; v.brj = brj; v.jt = jt;
        v.exp_pc = exp_pc; v.exp_bd = exp_bd;
        vecs.push_back(v);
    endtask

    task automatic free(input logic [31:0] exp_pc);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, J_NONE, exp_pc, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req_v);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        reset = 1; stall = 0; req = 0; eret = 0; D_brjump = 0;
        EPC = 0; D_pc = 0; D_rs = 0; D_imm16 = 0; D_index26 = 0; D_jtype = J_NONE;

        // rst stl rq er  epc dpc imm idx rs brj jt  -> pc bd
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, J_NONE, 32'h3000, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, J_NONE, 32'h3000, 0);
        free(32'h3004);
        free(32'h3008);
        free(32'h300C);
        add(0, 0, 0, 0, 0, 32'h3004, 16'hFFFF, 0, 0, 1, J_BR, 32'h3004, 1);
        add(0, 0, 0, 0, 0, 32'h3004, 16'hFFFF, 0, 0, 0, J_BR, 32'h3008, 1);
        free(32'h300C);
        add(0, 0, 0, 0, 0, 32'h3008, 0, 26'h0000C04, 0, 0, J_J, 32'h3010, 1);
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 0, 0, 32'h3000, 16'h0040, 0, 32'h5000, 1, J_BR, 32'h3010, 1);
        free(32'h3014);
        add(0, 1, 1, 1, 32'h3020, 32'h3000, 0, 0, 32'h5000, 0, J_JR, 32'h4180, 0);
        add(0, 1, 0, 1, 32'h3020, 32'h3000, 0, 0, 32'h5000, 0, J_JR, 32'h3020, 0);
        free(32'h3024);
        add(0, 0, 0, 0, 0, 32'h3020, 0, 0, 32'h3002, 0, J_JR, 32'h3002, 1);
        add(0, 0, 0, 0, 0, 32'h3020, 0, 0, 32'h7000, 0, J_JR, 32'h7000, 1);
        add(0, 0, 0, 0, 0, 32'h3020, 0, 0, 32'hFFFF_FFFC, 0, J_JR, 32'hFFFF_FFFC, 1);
        free(32'h0000_0000);
        free(32'h0000_0004);
        add(1, 1, 1, 1, 32'h3020, 0, 0, 0, 0, 0, J_JR, 32'h3000, 0);
        add(0, 0, 0, 0, 0, 32'h0FFF_FFFC, 0, 26'h0000C00, 0, 0, J_J, 32'h1000_3000, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, J_NONE, 32'h3000, 0);
        add(0, 0, 0, 0, 0, 32'h3000, 16'h0010, 0, 0, 1, J_BR, 32'h3044, 1);
        add(0, 0, 0, 1, 32'h3100, 32'h3000, 16'h0010, 0, 0, 1, J_BR, 32'h3100, 0);
        free(32'h3104);

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; stall = vecs[i].stl; req = vecs[i].rq; eret = vecs[i].er;
            EPC = vecs[i].epc; D_pc = vecs[i].dpc; D_imm16 = vecs[i].imm;
            D_index26 = vecs[i].idx; D_rs = vecs[i].rs; D_brjump = vecs[i].brj;
            D_jtype = vecs[i].jt;
            e.pc = vecs[i].exp_pc; e.bd = vecs[i].exp_bd; e.exc = model_exc(vecs[i].exp_pc);
            sb.push_back(e);
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1 at row %0d", i);
            end else begin
                e = sb.pop_front();
                check($sformatf("pc[%0d]", i), F_pc, e.pc);
                check($sformatf("bd[%0d]", i), {31'd0, F_bd}, {31'd0, e.bd});
                check($sformatf("exc[%0d]", i), {27'd0, F_exc_code}, {27'd0, e.exc});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
